add_result_queue: RTL and testbench
===================================

ADD_RESULT_QUEUE -- requirements
Module: add_result_queue

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the sum data width, matching the integer adder output width.
REQ-002 Parameter DEPTH, default 4, SHALL set the queue entry count; legal values are powers of two, at least 2.
REQ-003 Parameter TAG_W, default 5, SHALL set the destination-register tag width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 flush  input  1  SHALL request a synchronous discard of all entries.
REQ-007 in_valid  input  1  SHALL mark that in_sum/in_tag carry a new adder result.
REQ-008 in_ready  output  1  SHALL signal that the queue can accept an entry this cycle.
REQ-009 in_sum  input  WIDTH  SHALL carry the adder sum.
REQ-010 in_tag  input  TAG_W  SHALL carry the result's destination tag.
REQ-011 out_valid  output  1  SHALL mark that out_sum/out_tag hold the head entry.
REQ-012 out_ready  input  1  SHALL signal that writeback consumes the head entry this cycle.
REQ-013 out_sum  output  WIDTH  SHALL carry the head entry's sum.
REQ-014 out_tag  output  TAG_W  SHALL carry the head entry's tag.
REQ-015 count  output  $clog2(DEPTH)+1  SHALL report the number of occupied entries.

Function
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_sum/out_tag SHALL be read from the head storage slot, with no input-to-output bypass.
REQ-019 Latency: a push into an empty queue SHALL make out_valid high on the following cycle.
REQ-020 Order SHALL be strict FIFO; entries SHALL be neither dropped nor duplicated.
REQ-021 Write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, in_ready SHALL be low; in_valid SHALL be ignored, even if a pop occurs in the same cycle.
REQ-024 When empty, out_ready SHALL be ignored.
REQ-025 flush SHALL clear count and both pointers on the next edge; any same-cycle push or pop SHALL be discarded.
REQ-026 Storage contents SHALL NOT require reset; output data is don't-care while out_valid is low.

Reset
REQ-027 On rst_n low, count, both pointers and out_valid SHALL become 0 immediately, and in_ready SHALL become 1, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first push after deassertion SHALL land in slot 0.

Configuration
REQ-029 With macro ADD_RESULT_OVF_EN defined, the block SHALL add the following ports:
- input in_a_sign [1]
- input in_b_sign [1]
- output out_ovf [1]
REQ-030 With ADD_RESULT_OVF_EN defined, each pushed entry SHALL store ovf = (in_a_sign == in_b_sign) && (in_sum[WIDTH-1] != in_a_sign), and out_ovf SHALL present the head entry's flag.
REQ-031 Without ADD_RESULT_OVF_EN, these three ports and the per-entry flag storage SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then push sum 0x0000_0005 tag 3 with out_ready=0 -> next cycle: out_valid=1, out_sum=0x5, out_tag=3, count=1.
REQ-033 Push 0x11, 0x22, 0x33, 0x44 with out_ready=0 -> count=4, in_ready=0; a fifth push of 0x55 is ignored; pops yield 0x11, 0x22, 0x33, 0x44 in order.
REQ-034 Hold 2 entries, then push and pop simultaneously for 10 cycles -> count stays 2, the pointers wrap, and order is preserved.
REQ-035 Hold 3 entries, then assert flush with in_valid=1 -> next cycle: count=0, out_valid=0, in_ready=1.
REQ-036 Hold 2 entries, then drop rst_n between clock edges -> out_valid=0 and count=0 immediately, before the next edge.
REQ-037 With ADD_RESULT_OVF_EN: push in_sum 0x8000_0000, a_sign=0, b_sign=0 -> out_ovf=1; push in_sum 0x7FFF_FFFF, a_sign=1, b_sign=0 -> out_ovf=0.

Source files
------------

// File: rtl/add_result_queue.sv
// add_result_queue: small FIFO that buffers integer adder results (sum + tag)
// between the adder and the register-file writeback port.
// Optional feature macro: ADD_RESULT_OVF_EN adds per-entry signed-overflow
// flags (in_a_sign, in_b_sign -> out_ovf).
module add_result_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
`ifdef ADD_RESULT_OVF_EN
  ,
  input  logic                     in_a_sign,
  input  logic                     in_b_sign,
  output logic                     out_ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] sum_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  // Handshake flags come only from registered occupancy, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A flush cancels any transfer attempted in the same cycle.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the tail on every push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; out_valid guards its contents.
    if (push) begin
      sum_mem[wr_ptr] <= in_sum;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Head entry is read straight from storage; no input-to-output bypass.
  assign out_sum = sum_mem[rd_ptr];
  assign out_tag = tag_mem[rd_ptr];

`ifdef ADD_RESULT_OVF_EN
  logic ovf_mem [DEPTH];
  logic in_ovf;

  // Signed overflow: operands agree in sign but the sum's sign differs.
  assign in_ovf = (in_a_sign == in_b_sign) && (in_sum[WIDTH-1] != in_a_sign);

  // Overflow flag travels with its entry.
  always_ff @(posedge clk) begin
    if (push) ovf_mem[wr_ptr] <= in_ovf;
  end

  assign out_ovf = ovf_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_add_result_queue.sv
// tb_add_result_queue: directed scenarios with literal expectations followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_add_result_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] count;
`ifdef ADD_RESULT_OVF_EN
  logic             in_a_sign = 1'b0;
  logic             in_b_sign = 1'b0;
  logic             out_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } entry_t;

  entry_t model_q[$];

  add_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag),
    .count     (count)
`ifdef ADD_RESULT_OVF_EN
    ,
    .in_a_sign (in_a_sign),
    .in_b_sign (in_b_sign),
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; transfer rules read from pre-edge state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      entry_t e;
      do_push = in_valid && (model_q.size() < DEPTH) && !flush;
      do_pop  = out_ready && (model_q.size() > 0) && !flush;
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.sum = in_sum;
          e.tag = in_tag;
          e.ovf = 1'b0;
`ifdef ADD_RESULT_OVF_EN
          e.ovf = (in_a_sign == in_b_sign) && (in_sum[WIDTH-1] != in_a_sign);
`endif
          model_q.push_back(e);
        end
      end
    end
  end

  // Every falling edge out of reset: DUT outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mdl_count", 64'(count), 64'(model_q.size()));
      check("mdl_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check("mdl_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      if (model_q.size() != 0) begin
        check("mdl_out_sum", 64'(out_sum), 64'(model_q[0].sum));
        check("mdl_out_tag", 64'(out_tag), 64'(model_q[0].tag));
`ifdef ADD_RESULT_OVF_EN
        check("mdl_out_ovf", 64'(out_ovf), 64'(model_q[0].ovf));
`endif
      end
    end
  end

  // Advance one clock; inputs change and outputs are observed 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] s, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_sum   = s;
    in_tag   = t;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_arr [4];
    exp_arr = '{32'h11, 32'h22, 32'h33, 32'h44};

    // Reset: outputs settle while rst_n is low.
    #2 rst_n = 1'b0;
    #10;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push into empty queue: visible the next cycle.
    push_one(32'h0000_0005, 5'd3);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_sum", 64'(out_sum), 64'h5);
    check("lat_out_tag", 64'(out_tag), 64'd3);
    check("lat_count", 64'(count), 64'd1);
    drain();
    check("lat_drained", 64'(count), 64'd0);

    // Fill to full; a fifth push is refused, even alongside a pop.
    for (int i = 0; i < 4; i++) push_one(exp_arr[i], TAG_W'(i));
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    push_one(32'h55, 5'd9);
    check("full_ignore_count", 64'(count), 64'd4);
    check("pop0_sum", 64'(out_sum), 64'h11);
    in_valid  = 1'b1;
    in_sum    = 32'h55;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("full_pop_push_count", 64'(count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("pop%0d_sum", i), 64'(out_sum), 64'(exp_arr[i]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("fifo_empty", 64'(out_valid), 64'd0);

    // Steady-state push+pop with 2 entries held; pointers wrap.
    push_one(32'hA0, 5'd0);
    push_one(32'hA1, 5'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap_head%0d", i), 64'(out_sum), 64'(32'hA0 + i));
      in_valid  = 1'b1;
      in_sum    = 32'hA2 + i;
      in_tag    = TAG_W'(i + 2);
      out_ready = 1'b1;
      step();
      check($sformatf("wrap_count%0d", i), 64'(count), 64'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain();

    // Flush with 3 entries and a concurrent push.
    push_one(32'h1, 5'd1);
    push_one(32'h2, 5'd2);
    push_one(32'h3, 5'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 32'h4;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges with 2 entries held.
    push_one(32'h7, 5'd7);
    push_one(32'h8, 5'd8);
    #3 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_one(32'hBEEF, 5'd5);
    check("post_rst_sum", 64'(out_sum), 64'hBEEF);
    drain();

`ifdef ADD_RESULT_OVF_EN
    in_a_sign = 1'b0;
    in_b_sign = 1'b0;
    push_one(32'h8000_0000, 5'd1);
    check("ovf_set", 64'(out_ovf), 64'd1);
    drain();
    in_a_sign = 1'b1;
    in_b_sign = 1'b0;
    push_one(32'h7FFF_FFFF, 5'd2);
    check("ovf_clear", 64'(out_ovf), 64'd0);
    drain();
`endif

    // Randomized traffic with varying producer/consumer pressure.
    for (int i = 0; i < 2000; i++) begin
      int seg;
      seg       = (i / 250) % 4;
      in_valid  = ($urandom_range(0, 3) < (seg == 0 ? 3 : (seg == 1 ? 1 : 2)));
      out_ready = ($urandom_range(0, 3) < (seg == 0 ? 1 : (seg == 1 ? 3 : 2)));
      flush     = ($urandom_range(0, 63) == 0);
      in_sum    = $urandom;
      in_tag    = TAG_W'($urandom);
`ifdef ADD_RESULT_OVF_EN
      in_a_sign = 1'($urandom);
      in_b_sign = 1'($urandom);
`endif
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
